tcdm_remote_responder: RTL and testbench
========================================

// Module: tcdm_remote_responder
// PURPOSE
// - Target-side end of a remote TCDM link between groups: accepts request beats from another group's
//   master port (valid/ready), drives one SRAM bank of fixed read latency, returns one response per request.
// - Credit-based response buffer; the bank never stalls and responses are never dropped under resp_ready_i backpressure.
// - Sits in each group on every incoming tcdm_slave port, in front of the bank it targets.
// PARAMETERS
// - DataWidth    32  bank data width (bits); byte enable width = DataWidth/8
// - AddrWidth    10  bank-local word address width
// - MetaWidth    8   initiator tag (core/port id), returned unchanged with the response
// - BankLatency  1   cycles from bank_req_o to valid bank_rdata_i; >= 1
// - RespDepth    2   max outstanding requests (in flight + buffered); >= 1; full throughput needs >= BankLatency+1
// PORTS
// - clk_i         in   1             clock
// - rst_i         in   1             synchronous active-high reset
// - req_valid_i   in   1             request valid
// - req_ready_o   out  1             request ready
// - req_wen_i     in   1             1 = write, 0 = read
// - req_addr_i    in   AddrWidth     bank word address
// - req_wdata_i   in   DataWidth     write data
// - req_be_i      in   DataWidth/8   byte enables
// - req_meta_i    in   MetaWidth     initiator tag
// - resp_valid_o  out  1             response valid
// - resp_ready_i  in   1             response ready
// - resp_rdata_o  out  DataWidth     read data (0 for write responses)
// - resp_meta_o   out  MetaWidth     tag of the originating request
// - bank_req_o    out  1             bank access strobe
// - bank_we_o     out  1             bank write enable
// - bank_addr_o   out  AddrWidth     bank address
// - bank_wdata_o  out  DataWidth     bank write data
// - bank_be_o     out  DataWidth/8   bank byte enables
// - bank_rdata_i  in   DataWidth     bank read data, valid BankLatency cycles after bank_req_o
// BEHAVIOUR
// - Reset (rst_i=1 at a clock edge): credits := RespDepth, delay line and FIFO cleared.
//   While rst_i=1 all outputs 0 (incl. req_ready_o). Mid-operation reset drops in-flight and buffered
//   responses without emitting them.
// - Credit counter (registered, width $clog2(RespDepth+1)). req_ready_o = (credits != 0); independent of req_valid_i.
// - Accept = req_valid_i & req_ready_o: bank_req_o=1 same cycle; bank_we/addr/wdata/be are combinational
//   copies of the request. bank_req_o=0 otherwise; other bank outputs don't-care when bank_req_o=0.
// - Accept pushes {wen, meta} into a BankLatency-deep valid-tagged shift register.
// - At delay-line exit (cycle t+BankLatency): response {rdata = wen ? 0 : bank_rdata_i, meta} enters a
//   RespDepth-entry fall-through FIFO. FIFO empty -> resp_valid_o same cycle (min latency = BankLatency).
// - Responses leave strictly in acceptance order. resp_valid_o stays high with payload stable until resp_ready_i.
// - Credit update per cycle: -1 on accept, +1 on resp handshake; both -> unchanged. Never < 0 or > RespDepth
//   (assert). FIFO push when full is impossible by construction (assert).
// - Ready is not combinationally dependent on resp_ready_i (a freed credit is usable the next cycle).
// - Throughput: resp_ready_i=1 and RespDepth >= BankLatency+1 -> one accept per cycle sustained.
// STRUCTURE
// - Parameter checks via $fatal at elaboration: BankLatency>=1, RespDepth>=1, DataWidth%8==0.
// - mempool_pkg: no new types needed; the group instantiates with DataWidth/MetaWidth taken from the
//   tcdm_slave_req_t/tcdm_master_resp_t field widths.
// - Sub-module: tcdm_resp_fifo (fall-through, sync active-high reset, full/empty/usage outputs).
// - Top level holds the credit counter and delay line.
// TESTING
// - Reset: rst_i=1 for 3 cycles -> all outputs 0. First cycle after release: req_ready_o=1, credits=RespDepth.
// - Single read, default params: bank preloaded addr 0x005 = 0xDEADBEEF; read addr 0x005, meta 0x2A at cycle 0
//   -> bank_req_o=1, bank_we_o=0 at cycle 0; resp_valid_o=1, rdata 0xDEADBEEF, meta 0x2A at cycle 1.
// - Write: addr 0x010, wdata 0x12345678, be 4'b0011, meta 0x07 -> bank_we_o=1, be 0x3 at cycle 0;
//   response at cycle 1 with rdata 0, meta 0x07.
// - Backpressure, RespDepth=2: resp_ready_i=0, 4 back-to-back reads -> 2 accepted, req_ready_o=0 from cycle 2.
//   resp_ready_i=1 -> responses in order, payload stable while stalled, remaining 2 accepted, no loss.
// - Streaming: 100 random reads/writes, random meta, resp_ready_i=1, BankLatency=3, RespDepth=4
//   -> 1 accept/cycle, scoreboard matches data and order.
// - Simultaneous accept + pop at credits=1: credits stay 1, req_ready_o stays 1.
// - Reset asserted with 2 responses buffered and 1 in flight: no resp_valid_o after reset; credits=RespDepth.

Source files
------------

// File: rtl/tcdm_remote_responder_pkg.sv
// Shared defaults and helpers for the remote TCDM responder and its response FIFO.
package tcdm_remote_responder_pkg;

  localparam int unsigned DefDataWidth   = 32;
  localparam int unsigned DefAddrWidth   = 10;
  localparam int unsigned DefMetaWidth   = 8;
  localparam int unsigned DefBankLatency = 1;
  localparam int unsigned DefRespDepth   = 2;

  // Pointer width that stays legal for a single-entry buffer.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/tcdm_resp_fifo.sv
// Fall-through response FIFO: a push into an empty FIFO is visible on the output in the same cycle.
module tcdm_resp_fifo
  import tcdm_remote_responder_pkg::*;
#(
  parameter int unsigned Width = DefDataWidth + DefMetaWidth,
  parameter int unsigned Depth = DefRespDepth,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  usage_o
);

  localparam int unsigned PtrW = ptr_width(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  usage_q, usage_d;
  logic             bypass, store, drain;

  assign empty_o = (usage_q == '0);
  assign full_o  = (usage_q == CntW'(Depth));
  assign usage_o = usage_q;
  assign valid_o = ~empty_o | push_i;
  assign data_o  = empty_o ? push_data_i : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    usage_d  = usage_q;
    // An entry pushed and popped in the same cycle while empty never touches storage.
    bypass   = empty_o & push_i & pop_i;
    store    = push_i & ~bypass;
    drain    = pop_i & ~empty_o;
    if (store) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (drain) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({store, drain})
      2'b10:   usage_d = usage_q + CntW'(1);
      2'b01:   usage_d = usage_q - CntW'(1);
      default: usage_d = usage_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      usage_q  <= usage_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push_i && full_o));
      assert (!(pop_i && !valid_o));
    end
  end

endmodule

// File: rtl/tcdm_remote_responder.sv
// Target-side end of a remote TCDM link: credit-gated request acceptance, a fixed-latency bank
// tracking pipeline and an in-order response buffer that never forces the bank to stall.
module tcdm_remote_responder
  import tcdm_remote_responder_pkg::*;
#(
  parameter int unsigned DataWidth   = DefDataWidth,
  parameter int unsigned AddrWidth   = DefAddrWidth,
  parameter int unsigned MetaWidth   = DefMetaWidth,
  parameter int unsigned BankLatency = DefBankLatency,
  parameter int unsigned RespDepth   = DefRespDepth,
  localparam int unsigned BeWidth    = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_wen_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  input  logic [MetaWidth-1:0] req_meta_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [DataWidth-1:0] resp_rdata_o,
  output logic [MetaWidth-1:0] resp_meta_o,
  output logic                 bank_req_o,
  output logic                 bank_we_o,
  output logic [AddrWidth-1:0] bank_addr_o,
  output logic [DataWidth-1:0] bank_wdata_o,
  output logic [BeWidth-1:0]   bank_be_o,
  input  logic [DataWidth-1:0] bank_rdata_i
);

  localparam int unsigned CredW = $clog2(RespDepth + 1);
  localparam int unsigned RespW = DataWidth + MetaWidth;

  if (BankLatency < 1) begin : g_bad_latency
    $fatal(1, "tcdm_remote_responder: BankLatency must be >= 1");
  end
  if (RespDepth < 1) begin : g_bad_depth
    $fatal(1, "tcdm_remote_responder: RespDepth must be >= 1");
  end
  if (DataWidth % 8 != 0) begin : g_bad_width
    $fatal(1, "tcdm_remote_responder: DataWidth must be a multiple of 8");
  end

  logic [CredW-1:0]       credits_q, credits_d;
  logic [BankLatency-1:0] dl_valid_q, dl_valid_d;
  logic [BankLatency-1:0] dl_wen_q, dl_wen_d;
  logic [MetaWidth-1:0]   dl_meta_q [BankLatency];
  logic [MetaWidth-1:0]   dl_meta_d [BankLatency];

  logic             accept, resp_pop;
  logic             fifo_push, fifo_valid, fifo_full, fifo_empty;
  logic [RespW-1:0] fifo_push_data, fifo_data;
  logic [CredW-1:0] fifo_usage;

  // Every output is forced low while reset is held, including the request-side ready.
  assign req_ready_o  = ~rst_i & (credits_q != '0);
  assign accept       = req_valid_i & req_ready_o;
  assign bank_req_o   = accept;
  assign bank_we_o    = ~rst_i & req_wen_i;
  assign bank_addr_o  = rst_i ? '0 : req_addr_i;
  assign bank_wdata_o = rst_i ? '0 : req_wdata_i;
  assign bank_be_o    = rst_i ? '0 : req_be_i;

  assign resp_valid_o = ~rst_i & fifo_valid;
  assign resp_rdata_o = rst_i ? '0 : fifo_data[RespW-1 -: DataWidth];
  assign resp_meta_o  = rst_i ? '0 : fifo_data[MetaWidth-1:0];
  assign resp_pop     = resp_valid_o & resp_ready_i;

  assign fifo_push      = dl_valid_q[BankLatency-1];
  assign fifo_push_data = {dl_wen_q[BankLatency-1] ? {DataWidth{1'b0}} : bank_rdata_i,
                           dl_meta_q[BankLatency-1]};

  always_comb begin
    dl_valid_d    = '0;
    dl_wen_d      = '0;
    dl_meta_d     = dl_meta_q;
    dl_valid_d[0] = accept;
    dl_wen_d[0]   = req_wen_i;
    dl_meta_d[0]  = req_meta_i;
    for (int i = 1; i < BankLatency; i++) begin
      dl_valid_d[i] = dl_valid_q[i-1];
      dl_wen_d[i]   = dl_wen_q[i-1];
      dl_meta_d[i]  = dl_meta_q[i-1];
    end
  end

  // One credit per outstanding request, whether still in the bank or waiting in the FIFO.
  always_comb begin
    credits_d = credits_q;
    case ({accept, resp_pop})
      2'b10:   credits_d = credits_q - CredW'(1);
      2'b01:   credits_d = credits_q + CredW'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credits_q  <= CredW'(RespDepth);
      dl_valid_q <= '0;
    end else begin
      credits_q  <= credits_d;
      dl_valid_q <= dl_valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    dl_wen_q  <= dl_wen_d;
    dl_meta_q <= dl_meta_d;
  end

  tcdm_resp_fifo #(
    .Width (RespW),
    .Depth (RespDepth)
  ) i_resp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (fifo_push),
    .push_data_i (fifo_push_data),
    .pop_i       (resp_pop),
    .valid_o     (fifo_valid),
    .data_o      (fifo_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .usage_o     (fifo_usage)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (credits_q <= CredW'(RespDepth));
      assert (!(resp_pop && !accept && credits_q == CredW'(RespDepth)));
      assert (!(fifo_push && fifo_full));
      assert (fifo_empty || credits_q != CredW'(RespDepth));
      assert (fifo_usage <= CredW'(RespDepth) - credits_q);
    end
  end

endmodule

// File: tb/tb_tcdm_remote_responder.sv
// Bench for tcdm_remote_responder: a default-parameter instance driven from a vector table and a
// BankLatency=3 / RespDepth=4 instance for streaming and mid-operation reset.
module tb_tcdm_remote_responder;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int MW = 8;
  localparam int BW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic          rst_a, req_valid_a, req_ready_a, req_wen_a, resp_valid_a, resp_ready_a;
  logic [AW-1:0] req_addr_a, bank_addr_a;
  logic [DW-1:0] req_wdata_a, resp_rdata_a, bank_wdata_a, bank_rdata_a;
  logic [BW-1:0] req_be_a, bank_be_a;
  logic [MW-1:0] req_meta_a, resp_meta_a;
  logic          bank_req_a, bank_we_a;

  logic          rst_b, req_valid_b, req_ready_b, req_wen_b, resp_valid_b, resp_ready_b;
  logic [AW-1:0] req_addr_b, bank_addr_b;
  logic [DW-1:0] req_wdata_b, resp_rdata_b, bank_wdata_b, bank_rdata_b;
  logic [BW-1:0] req_be_b, bank_be_b;
  logic [MW-1:0] req_meta_b, resp_meta_b;
  logic          bank_req_b, bank_we_b;

  tcdm_remote_responder dut_a (
    .clk_i(clk), .rst_i(rst_a),
    .req_valid_i(req_valid_a), .req_ready_o(req_ready_a), .req_wen_i(req_wen_a),
    .req_addr_i(req_addr_a), .req_wdata_i(req_wdata_a), .req_be_i(req_be_a), .req_meta_i(req_meta_a),
    .resp_valid_o(resp_valid_a), .resp_ready_i(resp_ready_a),
    .resp_rdata_o(resp_rdata_a), .resp_meta_o(resp_meta_a),
    .bank_req_o(bank_req_a), .bank_we_o(bank_we_a), .bank_addr_o(bank_addr_a),
    .bank_wdata_o(bank_wdata_a), .bank_be_o(bank_be_a), .bank_rdata_i(bank_rdata_a)
  );

  tcdm_remote_responder #(.BankLatency(3), .RespDepth(4)) dut_b (
    .clk_i(clk), .rst_i(rst_b),
    .req_valid_i(req_valid_b), .req_ready_o(req_ready_b), .req_wen_i(req_wen_b),
    .req_addr_i(req_addr_b), .req_wdata_i(req_wdata_b), .req_be_i(req_be_b), .req_meta_i(req_meta_b),
    .resp_valid_o(resp_valid_b), .resp_ready_i(resp_ready_b),
    .resp_rdata_o(resp_rdata_b), .resp_meta_o(resp_meta_b),
    .bank_req_o(bank_req_b), .bank_we_o(bank_we_b), .bank_addr_o(bank_addr_b),
    .bank_wdata_o(bank_wdata_b), .bank_be_o(bank_be_b), .bank_rdata_i(bank_rdata_b)
  );

  // Bank models: memory reloaded with a fixed pattern while the matching DUT is in reset.
  logic [DW-1:0] mem_a [1024];
  logic [DW-1:0] rd_pipe_a;
  logic [DW-1:0] mem_b [1024];
  logic [DW-1:0] rd_pipe_b [3];

  always @(posedge clk) begin
    if (rst_a) begin
      for (int i = 0; i < 1024; i++) mem_a[i] <= (i == 5) ? 32'hDEADBEEF : (32'hA000_0000 | 32'(i));
    end else if (bank_req_a && bank_we_a) begin
      for (int k = 0; k < BW; k++) if (bank_be_a[k]) mem_a[bank_addr_a][8*k +: 8] <= bank_wdata_a[8*k +: 8];
    end
    rd_pipe_a <= (bank_req_a && !bank_we_a) ? mem_a[bank_addr_a] : 32'hBAD0BAD0;
  end
  assign bank_rdata_a = rd_pipe_a;

  always @(posedge clk) begin
    if (rst_b) begin
      for (int i = 0; i < 1024; i++) mem_b[i] <= 32'hB000_0000 | 32'(i);
    end else if (bank_req_b && bank_we_b) begin
      for (int k = 0; k < BW; k++) if (bank_be_b[k]) mem_b[bank_addr_b][8*k +: 8] <= bank_wdata_b[8*k +: 8];
    end
    rd_pipe_b[0] <= (bank_req_b && !bank_we_b) ? mem_b[bank_addr_b] : 32'hBAD0BAD0;
    rd_pipe_b[1] <= rd_pipe_b[0];
    rd_pipe_b[2] <= rd_pipe_b[1];
  end
  assign bank_rdata_b = rd_pipe_b[2];

  typedef struct {
    logic          rst, valid, wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    logic [MW-1:0] meta;
    logic          rr;
    logic          e_ready, e_breq, e_bwe;
    logic [AW-1:0] e_baddr;
    logic [BW-1:0] e_bbe;
    logic          e_rvalid;
    logic [DW-1:0] e_rdata;
    logic [MW-1:0] e_rmeta;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [MW-1:0] meta;
  } resp_t;

  vec_t          vecs [19];
  resp_t         exp_q [$];
  logic [DW-1:0] ref_b [1024];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_a        = v.rst;
    req_valid_a  = v.valid;
    req_wen_a    = v.wen;
    req_addr_a   = v.addr;
    req_wdata_a  = v.wdata;
    req_be_a     = v.be;
    req_meta_a   = v.meta;
    resp_ready_a = v.rr;
  endtask

  task automatic driveB(input logic valid, input logic wen, input logic [AW-1:0] addr,
                        input logic [MW-1:0] meta, input logic rr);
    req_valid_b  = valid;
    req_wen_b    = wen;
    req_addr_b   = addr;
    req_wdata_b  = '0;
    req_be_b     = 4'hF;
    req_meta_b   = meta;
    resp_ready_b = rr;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int issued, received, stalls, got;
    resp_t e;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [BW-1:0] be;
    logic          w;

    // Fields: rst valid wen addr wdata be meta rr | ready breq bwe baddr bbe rvalid rdata rmeta
    for (int i = 0; i < 3; i++)
      vecs[i] = '{1'b1,1'b1,1'b0,10'h005,32'h0,4'hF,8'h2A,1'b1, 1'b0,1'b0,1'b0,10'h000,4'h0,1'b0,32'h0,8'h00};
    vecs[3]  = '{1'b0,1'b0,1'b0,10'h000,32'h0,4'h0,8'h00,1'b1, 1'b1,1'b0,1'b0,10'h000,4'h0,1'b0,32'h0,8'h00};
    vecs[4]  = '{1'b0,1'b1,1'b0,10'h005,32'h0,4'hF,8'h2A,1'b1, 1'b1,1'b1,1'b0,10'h005,4'hF,1'b0,32'h0,8'h00};
    vecs[5]  = '{1'b0,1'b0,1'b0,10'h000,32'h0,4'h0,8'h00,1'b1, 1'b1,1'b0,1'b0,10'h000,4'h0,1'b1,32'hDEADBEEF,8'h2A};
    vecs[6]  = '{1'b0,1'b1,1'b1,10'h010,32'h12345678,4'h3,8'h07,1'b1, 1'b1,1'b1,1'b1,10'h010,4'h3,1'b0,32'h0,8'h00};
    vecs[7]  = '{1'b0,1'b0,1'b0,10'h000,32'h0,4'h0,8'h00,1'b1, 1'b1,1'b0,1'b0,10'h000,4'h0,1'b1,32'h0,8'h07};
    vecs[8]  = '{1'b0,1'b1,1'b0,10'h010,32'h0,4'hF,8'h11,1'b1, 1'b1,1'b1,1'b0,10'h010,4'hF,1'b0,32'h0,8'h00};
    vecs[9]  = '{1'b0,1'b0,1'b0,10'h000,32'h0,4'h0,8'h00,1'b1, 1'b1,1'b0,1'b0,10'h000,4'h0,1'b1,32'hA0005678,8'h11};
    vecs[10] = '{1'b0,1'b1,1'b0,10'h001,32'h0,4'hF,8'h01,1'b0, 1'b1,1'b1,1'b0,10'h001,4'hF,1'b0,32'h0,8'h00};
    vecs[11] = '{1'b0,1'b1,1'b0,10'h002,32'h0,4'hF,8'h02,1'b0, 1'b1,1'b1,1'b0,10'h002,4'hF,1'b1,32'hA0000001,8'h01};
    vecs[12] = '{1'b0,1'b1,1'b0,10'h003,32'h0,4'hF,8'h03,1'b0, 1'b0,1'b0,1'b0,10'h000,4'h0,1'b1,32'hA0000001,8'h01};
    vecs[13] = '{1'b0,1'b1,1'b0,10'h003,32'h0,4'hF,8'h03,1'b0, 1'b0,1'b0,1'b0,10'h000,4'h0,1'b1,32'hA0000001,8'h01};
    vecs[14] = '{1'b0,1'b1,1'b0,10'h003,32'h0,4'hF,8'h03,1'b1, 1'b0,1'b0,1'b0,10'h000,4'h0,1'b1,32'hA0000001,8'h01};
    vecs[15] = '{1'b0,1'b1,1'b0,10'h003,32'h0,4'hF,8'h03,1'b1, 1'b1,1'b1,1'b0,10'h003,4'hF,1'b1,32'hA0000002,8'h02};
    vecs[16] = '{1'b0,1'b1,1'b0,10'h004,32'h0,4'hF,8'h04,1'b1, 1'b1,1'b1,1'b0,10'h004,4'hF,1'b1,32'hA0000003,8'h03};
    vecs[17] = '{1'b0,1'b0,1'b0,10'h000,32'h0,4'h0,8'h00,1'b1, 1'b1,1'b0,1'b0,10'h000,4'h0,1'b1,32'hA0000004,8'h04};
    vecs[18] = '{1'b0,1'b0,1'b0,10'h000,32'h0,4'h0,8'h00,1'b1, 1'b1,1'b0,1'b0,10'h000,4'h0,1'b0,32'h0,8'h00};

    for (int i = 0; i < 1024; i++) ref_b[i] = 32'hB000_0000 | 32'(i);

    applyStimulus(vecs[0]);
    rst_b = 1'b1;
    driveB(1'b0, 1'b0, '0, '0, 1'b0);

    $display("[TB] table phase, default parameters");
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      applyStimulus(vecs[i]);
      #3;
      checkOutput($sformatf("v%0d.req_ready", i), req_ready_a, vecs[i].e_ready);
      checkOutput($sformatf("v%0d.bank_req", i), bank_req_a, vecs[i].e_breq);
      checkOutput($sformatf("v%0d.resp_valid", i), resp_valid_a, vecs[i].e_rvalid);
      if (vecs[i].rst) begin
        checkOutput($sformatf("v%0d.rst_bank_out", i),
                    {bank_we_a, bank_addr_a, bank_be_a} | bank_wdata_a, 32'h0);
        checkOutput($sformatf("v%0d.rst_resp_out", i), resp_rdata_a | 32'(resp_meta_a), 32'h0);
      end
      if (vecs[i].e_breq) begin
        checkOutput($sformatf("v%0d.bank_we", i), bank_we_a, vecs[i].e_bwe);
        checkOutput($sformatf("v%0d.bank_addr", i), bank_addr_a, vecs[i].e_baddr);
        checkOutput($sformatf("v%0d.bank_be", i), bank_be_a, vecs[i].e_bbe);
        if (vecs[i].e_bwe) checkOutput($sformatf("v%0d.bank_wdata", i), bank_wdata_a, vecs[i].wdata);
      end
      if (vecs[i].e_rvalid) begin
        checkOutput($sformatf("v%0d.resp_rdata", i), resp_rdata_a, vecs[i].e_rdata);
        checkOutput($sformatf("v%0d.resp_meta", i), resp_meta_a, vecs[i].e_rmeta);
      end
    end

    $display("[TB] streaming phase, BankLatency=3 RespDepth=4");
    @(posedge clk); #1;
    rst_b = 1'b0;
    driveB(1'b0, 1'b0, '0, '0, 1'b1);
    #3;
    checkOutput("b.reset_release_ready", req_ready_b, 1);
    checkOutput("b.reset_release_valid", resp_valid_b, 0);

    issued = 0; received = 0; stalls = 0;
    for (int cyc = 0; cyc < 400 && received < 100; cyc++) begin
      @(posedge clk); #1;
      if (issued < 100) begin
        w  = 1'($urandom_range(0, 1));
        a  = 10'($urandom_range(0, 15));
        wd = $urandom;
        be = 4'($urandom_range(0, 15));
        driveB(1'b1, w, a, 8'($urandom_range(0, 255)), 1'b1);
        req_wdata_b = wd;
        req_be_b    = be;
      end else begin
        driveB(1'b0, 1'b0, '0, '0, 1'b1);
      end
      #3;
      if (req_valid_b) begin
        if (!req_ready_b) stalls++;
        else begin
          if (req_wen_b) begin
            for (int k = 0; k < BW; k++) if (req_be_b[k]) ref_b[req_addr_b][8*k +: 8] = req_wdata_b[8*k +: 8];
            e.data = '0;
          end else begin
            e.data = ref_b[req_addr_b];
          end
          e.meta = req_meta_b;
          exp_q.push_back(e);
          issued++;
        end
      end
      if (resp_valid_b) begin
        if (exp_q.size() == 0) checkOutput("stream.spurious_resp", resp_valid_b, 0);
        else begin
          e = exp_q.pop_front();
          checkOutput($sformatf("stream.rdata[%0d]", received), resp_rdata_b, e.data);
          checkOutput($sformatf("stream.meta[%0d]", received), resp_meta_b, e.meta);
          received++;
        end
      end
    end
    checkOutput("stream.stall_cycles", stalls, 0);
    checkOutput("stream.received", received, 100);

    $display("[TB] mid-operation reset phase");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      driveB(1'b1, 1'b0, 10'(32'h20 + c), 8'(32'hC0 + c), 1'b0);
    end
    @(posedge clk); #1;
    driveB(1'b0, 1'b0, '0, '0, 1'b0);
    #3;
    checkOutput("mr.c3_valid", resp_valid_b, 1);
    checkOutput("mr.c3_meta", resp_meta_b, 8'hC0);
    @(posedge clk); #4;
    checkOutput("mr.c4_meta_stable", resp_meta_b, 8'hC0);
    checkOutput("mr.c4_rdata_stable", resp_rdata_b, 32'hB0000020);
    @(posedge clk); #1;
    rst_b = 1'b1;
    #3;
    checkOutput("mr.in_reset_valid", resp_valid_b, 0);
    checkOutput("mr.in_reset_ready", req_ready_b, 0);
    @(posedge clk); #1;
    rst_b = 1'b0;
    #3;
    checkOutput("mr.release_valid", resp_valid_b, 0);
    checkOutput("mr.release_ready", req_ready_b, 1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      driveB(1'b1, 1'b0, 10'(32'h30 + c), 8'(32'hD0 + c), 1'b0);
      #3;
      checkOutput($sformatf("mr.credit_accept%0d", c), req_ready_b, 1);
      if (c < 3) checkOutput($sformatf("mr.no_stale_resp%0d", c), resp_valid_b, 0);
    end
    @(posedge clk); #1;
    driveB(1'b1, 1'b0, 10'h034, 8'hD4, 1'b0);
    #3;
    checkOutput("mr.credits_exhausted", req_ready_b, 0);

    got = 0;
    for (int c = 0; c < 12 && got < 4; c++) begin
      @(posedge clk); #1;
      driveB(1'b0, 1'b0, '0, '0, 1'b1);
      #3;
      if (resp_valid_b) begin
        checkOutput($sformatf("mr.drain_meta%0d", got), resp_meta_b, 32'hD0 + got);
        checkOutput($sformatf("mr.drain_rdata%0d", got), resp_rdata_b, 32'hB0000030 + got);
        got++;
      end
    end
    checkOutput("mr.drain_count", got, 4);
    @(posedge clk); #4;
    checkOutput("mr.drained_idle", resp_valid_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
